// File: rtl/matrix_stream_ctrl_2x2_pkg.sv
// matrix_pkg: shared types and constants for the 2x2 matrix streaming controller.
//   DEF_DW / DEF_CW : default element and result widths
//   state_t         : controller FSM states
//   IDX_*           : arrival order of the eight input elements
//   pack_2x2 / unpack_c : helpers for the flattened 2x2 buses
//                         (element [i][j] lives at bits W*(2i+j) +: W)
package matrix_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN,
        ST_ERR
    } state_t;

    localparam logic [2:0] IDX_A00 = 3'd0;
    localparam logic [2:0] IDX_A01 = 3'd1;
    localparam logic [2:0] IDX_A10 = 3'd2;
    localparam logic [2:0] IDX_A11 = 3'd3;
    localparam logic [2:0] IDX_B00 = 3'd4;
    localparam logic [2:0] IDX_B01 = 3'd5;
    localparam logic [2:0] IDX_B10 = 3'd6;
    localparam logic [2:0] IDX_B11 = 3'd7;

    function automatic logic [4*DEF_DW-1:0] pack_2x2(
        input logic [DEF_DW-1:0] e00,
        input logic [DEF_DW-1:0] e01,
        input logic [DEF_DW-1:0] e10,
        input logic [DEF_DW-1:0] e11
    );
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [DEF_CW-1:0] unpack_c(
        input logic [4*DEF_CW-1:0] bus,
        input logic [1:0]          idx
    );
        return bus[DEF_CW*idx +: DEF_CW];
    endfunction

endpackage

// File: rtl/matrix_stream_ctrl_2x2_out_ser.sv
// matrix_out_ser: holds the four C results and serialises them onto a
// valid/ready stream in order C00, C01, C10, C11.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture c_in and start a new burst
//   c_in        : packed C (element [i][j] at CW*(2i+j) +: CW)
//   out_ready   : downstream accepts when high with out_valid
//   out_valid   : a result is presented
//   out_data    : current result (0 when not valid)
//   out_last    : high with C11
//   done        : handshake of C11 this cycle
module matrix_out_ser
    import matrix_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [4*CW-1:0] c_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [CW-1:0]   out_data,
    output logic            out_last,
    output logic            done
);

    logic [CW-1:0] r_c [4];
    logic [1:0]    r_idx;
    logic          r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            for (int unsigned i = 0; i < 4; i++) r_c[i] <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_idx   <= '0;
            for (int unsigned i = 0; i < 4; i++) r_c[i] <= c_in[CW*i +: CW];
        end else if (r_valid && out_ready) begin
            // Index wraps 3 -> 0 on its own, ready for the next burst.
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_valid ? r_c[r_idx] : '0;
    assign out_last  = r_valid && (r_idx == 2'd3);
    assign done      = r_valid && out_ready && (r_idx == 2'd3);

endmodule

// File: rtl/matrix_stream_ctrl_2x2.sv
// matrix_stream_ctrl_2x2: streaming front/back end for a 2x2 matrix multiplier.
// Collects A then B (8 signed elements) from a valid/ready stream, pulses
// mm_start, waits for mm_done (bounded by TIMEOUT cycles), captures C and
// returns the four results over a valid/ready stream.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : element input, order A00..A11, B00..B11
//   mm_start, mm_a, mm_b   : multiplier request (A/B held while busy)
//   mm_c, mm_done          : multiplier response
//   out_valid/out_ready/out_data/out_last : result output, C00..C11
//   err                    : one-cycle pulse on multiplier timeout
//   busy                   : high outside IDLE and LOAD
module matrix_stream_ctrl_2x2
    import matrix_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            mm_start,
    output logic [4*DW-1:0] mm_a,
    output logic [4*DW-1:0] mm_b,
    input  logic [4*CW-1:0] mm_c,
    input  logic            mm_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_data,
    output logic            out_last,
    output logic            err,
    output logic            busy
);

    localparam int unsigned    TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic [4*DW-1:0] r_a;
    logic [4*DW-1:0] r_b;
    logic            w_in_hs;
    logic            w_load_c;
    logic            w_ser_done;

    assign w_in_hs  = (r_state == ST_LOAD) && in_valid;
    assign w_load_c = (r_state == ST_WAIT) && mm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_LOAD;
            ST_LOAD:  if (w_in_hs && (r_cnt == IDX_B11)) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            // done on the final permitted cycle wins over the timeout
            ST_WAIT:  if (mm_done)               w_next = ST_DRAIN;
                      else if (r_tcnt == TMAX)   w_next = ST_ERR;
            ST_DRAIN: if (w_ser_done) w_next = ST_LOAD;
            ST_ERR:   w_next = ST_LOAD;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mm_start = 1'b0;
        err      = 1'b0;
        busy     = 1'b1;
        case (r_state)
            ST_IDLE:  busy     = 1'b0;
            ST_LOAD:  begin in_ready = 1'b1; busy = 1'b0; end
            ST_START: mm_start = 1'b1;
            ST_ERR:   err      = 1'b1;
            default:  ;
        endcase
    end

    // Element counter and A/B slots: counter bit 2 selects B, bits 1:0 the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_in_hs) begin
            r_cnt <= (r_cnt == IDX_B11) ? '0 : r_cnt + 3'd1;
            if (!r_cnt[2]) r_a[DW*r_cnt[1:0] +: DW] <= in_data;
            else           r_b[DW*r_cnt[1:0] +: DW] <= in_data;
        end
    end

    // Timeout counter is held at 0 outside WAIT so it starts from 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_tcnt <= '0;
        else if (r_state != ST_WAIT)          r_tcnt <= '0;
        else if (!mm_done && r_tcnt != TMAX)  r_tcnt <= r_tcnt + 1'b1;
    end

    assign mm_a = r_a;
    assign mm_b = r_b;

    matrix_out_ser #(
        .CW(CW)
    ) u_out_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load_c),
        .c_in      (mm_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (w_ser_done)
    );

endmodule

// File: tb/tb_matrix_stream_ctrl_2x2.sv
// Directed bench for matrix_stream_ctrl_2x2 with a behavioural multiplier
// and an expected-result queue filled when each matrix pair is sent.
module tb_matrix_stream_ctrl_2x2;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mm_start;
    logic [31:0] mm_a;
    logic [31:0] mm_b;
    logic [63:0] mm_c;
    logic        mm_done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];

    // multiplier model controls
    int          m_delay = 2;
    bit          m_never = 0;
    bit          m_spur  = 0;
    int          m_cnt;
    bit          m_busy;
    logic [31:0] m_a;
    logic [31:0] m_b;

    matrix_stream_ctrl_2x2 #(
        .DW(8),
        .CW(16),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c),
        .mm_done   (mm_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mat_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] c;
        int          s;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'($signed(a[8*(2*i+k) +: 8])) * int'($signed(b[8*(2*k+j) +: 8]));
                c[16*(2*i+j) +: 16] = s[15:0];
            end
        end
        return c;
    endfunction

    // Behavioural multiplier: done k cycles after the start pulse is seen.
    initial begin
        mm_done = 1'b0;
        mm_c    = '0;
        m_busy  = 0;
        m_cnt   = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                mm_done = 1'b0;
                m_busy  = 0;
            end else begin
                mm_done = 1'b0;
                mm_c    = {$urandom, $urandom};
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mm_done = 1'b1;
                        mm_c    = mat_mul(m_a, m_b);
                        m_busy  = 0;
                    end
                end
                if (mm_start) begin
                    mm_done = m_spur;
                    if (!m_never) begin
                        m_busy = 1;
                        m_cnt  = m_delay;
                        m_a    = mm_a;
                        m_b    = mm_b;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_outputs",
            {in_ready, mm_start, mm_a, mm_b, out_valid, out_data, out_last, err, busy}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("first_in_ready", in_ready, 1'b1);
        chk("load_busy", busy, 1'b0);
    endtask

    task automatic push_c(input logic [63:0] c);
        for (int q = 0; q < 4; q++) exp_q.push_back(c[16*q +: 16]);
    endtask

    // Returns at the negedge of the cycle after the 8th handshake (START).
    task automatic send_pair(input logic [7:0] e [8], input bit gaps);
        int sent = 0;
        int cyc  = 0;
        bit hs;
        while (sent < 8 && cyc < 200) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = e[sent];
            hs       = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (hs) sent++;
        end
        chk("load_count", sent, 8);
        in_data = 8'h5A;
        chk("start_pulse", mm_start, 1'b1);
        chk("start_in_ready", in_ready, 1'b0);
        chk("start_busy", busy, 1'b1);
    endtask

    task automatic drain(input int lat, input bit bp, input int n_take);
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int cyc  = 1;
        int got  = 0;
        int ncyc = 0;
        int pi   = 0;
        bit stalled = 0;
        logic [16:0] held;
        logic [15:0] ev;
        @(negedge clk);
        chk("start_one_cycle", mm_start, 1'b0);
        while (!out_valid && cyc < lat + 40) begin
            chk("wait_no_err", err, 1'b0);
            chk("wait_in_ready", in_ready, 1'b0);
            @(negedge clk);
            cyc++;
        end
        chk("first_out_latency", cyc, lat);
        while (got < n_take && ncyc < 50) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_in_ready", in_ready, 1'b0);
            if (stalled) chk("stall_stable", {out_data, out_last}, held);
            out_ready = bp ? pat[pi % 7][0] : 1'b1;
            pi++;
            if (out_ready) begin
                ev = exp_q.size() > 0 ? exp_q.pop_front() : 16'hDEAD;
                chk("out_data", out_data, ev);
                chk("out_last", out_last, got == 3);
                got++;
                stalled = 0;
                if (got == n_take) in_valid = 1'b0;
            end else begin
                stalled = 1;
                held    = {out_data, out_last};
            end
            @(negedge clk);
            ncyc++;
        end
        chk("drain_count", got, n_take);
        out_ready = 1'b0;
        if (n_take == 4) begin
            chk("drain_cycles", ncyc, bp ? 7 : 4);
            chk("reload_in_ready", in_ready, 1'b1);
            chk("post_drain_valid", out_valid, 1'b0);
            chk("post_drain_busy", busy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] e [8];
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // basic, with a spurious done during START
        e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_q.push_back(16'd19); exp_q.push_back(16'd22);
        exp_q.push_back(16'd43); exp_q.push_back(16'd50);
        m_delay = 2; m_spur = 1;
        send_pair(e, 0);
        drain(3, 0, 4);
        m_spur = 0;

        // signed, packing checked per slot
        e = '{8'hFF, 8'd2, 8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'd8};
        exp_q.push_back(16'd9);     exp_q.push_back(16'd22);
        exp_q.push_back(16'hFFF3);  exp_q.push_back(16'hFFCE);
        m_delay = 1;
        send_pair(e, 0);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("mm_a_slot%0d", s), mm_a[8*s +: 8], e[s]);
            chk($sformatf("mm_b_slot%0d", s), mm_b[8*s +: 8], e[4+s]);
        end
        drain(2, 0, 4);

        // input gaps and output backpressure
        for (int s = 0; s < 8; s++) e[s] = 8'($urandom);
        push_c(mat_mul({e[3], e[2], e[1], e[0]}, {e[7], e[6], e[5], e[4]}));
        m_delay = 3;
        send_pair(e, 1);
        drain(4, 1, 4);

        // timeout: no done ever
        e = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        m_never = 1;
        send_pair(e, 0);
        in_valid = 1'b0;
        for (int o = 1; o <= TO + 2; o++) begin
            @(negedge clk);
            chk($sformatf("timeout_err_c%0d", o), err, o == TO + 1);
            chk("timeout_no_valid", out_valid, 1'b0);
            if (o == TO + 2) chk("timeout_in_ready", in_ready, 1'b1);
        end
        m_never = 0;

        // next pair after a timeout completes normally
        for (int s = 0; s < 8; s++) e[s] = 8'($urandom);
        push_c(mat_mul({e[3], e[2], e[1], e[0]}, {e[7], e[6], e[5], e[4]}));
        m_delay = 3;
        send_pair(e, 0);
        drain(4, 0, 4);

        // done on the final permitted WAIT cycle
        e = '{8'h80, 8'h7F, 8'hFF, 8'd1, 8'h7F, 8'h80, 8'd1, 8'hFF};
        push_c(mat_mul({e[3], e[2], e[1], e[0]}, {e[7], e[6], e[5], e[4]}));
        m_delay = TO;
        send_pair(e, 0);
        drain(TO + 1, 0, 4);

        // reset after two results, then a fresh pair
        e = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
        push_c(mat_mul({e[3], e[2], e[1], e[0]}, {e[7], e[6], e[5], e[4]}));
        m_delay = 2;
        send_pair(e, 0);
        drain(3, 0, 2);
        do_reset();
        exp_q.delete();
        e = '{8'd2, 8'hFE, 8'd3, 8'd1, 8'hF0, 8'd4, 8'd6, 8'hF9};
        push_c(mat_mul({e[3], e[2], e[1], e[0]}, {e[7], e[6], e[5], e[4]}));
        send_pair(e, 0);
        drain(3, 0, 4);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_stream_ctrl_2x2.md
# matrix_stream_ctrl_2x2

Streaming front/back end for the `matrix_mul_2x2` datapath. It accepts eight signed elements over a valid/ready input stream and packs them into A and B. It drives the multiplier's start/done handshake as initiator, captures C, and returns the four results over a valid/ready output stream. It sits between the system streaming fabric and `matrix_mul_2x2`.

## Interface
- `DW`, 8: element width of A and B, signed.
- `CW`, 16: result width of C, signed.
- `TIMEOUT`, 64: maximum number of WAIT cycles for `mm_done`; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  input element accepted when high with `in_valid`.
- `in_data`  in  DW  element; order A00, A01, A10, A11, B00, B01, B10, B11.
- `mm_start`  out  1  one-cycle start pulse to multiplier.
- `mm_a`  out  4*DW  packed A; element [i][j] at bits DW*(2i+j) +: DW.
- `mm_b`  out  4*DW  packed B, same packing.
- `mm_c`  in  4*CW  packed C from multiplier, same packing with CW.
- `mm_done`  in  1  multiplier done.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accepted when high with `out_valid`.
- `out_data`  out  CW  result; order C00, C01, C10, C11.
- `out_last`  out  1  high with C11.
- `err`  out  1  one-cycle pulse on multiplier timeout.
- `busy`  out  1  high in every state except IDLE and LOAD.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN, ERR.
- IDLE: reset state. Moves to LOAD on the next cycle unconditionally.
- LOAD: `in_ready`=1. A 3-bit element counter increments on each handshake, and the element is written to its A/B slot. The 8th handshake moves the FSM to START and clears the counter.
- START: `mm_start`=1 for exactly one cycle, then WAIT. `mm_a`/`mm_b` are registered and hold stable from the 8th load until the FSM re-enters LOAD.
- WAIT: `mm_done` is sampled every cycle, and the timeout counter starts at 0 on WAIT entry.
  - `mm_done`=1: capture `mm_c` into the C register, go to DRAIN.
  - Otherwise the counter increments. If TIMEOUT WAIT cycles elapse without done, go to ERR.
  - `mm_done` high during START is ignored.
- ERR: `err`=1 for one cycle. A/B are discarded, no output is produced, then LOAD.
- DRAIN: a 2-bit output index selects the C register element.
  - `out_valid`=1 throughout DRAIN.
  - `out_data` and `out_last` hold stable while `out_valid` is high and `out_ready` is low.
  - The handshake on index 3 (`out_last`=1) moves the FSM to LOAD.
- No arithmetic is performed. Elements pass through bit-exact as two's complement.
- Simultaneous events:
  - `in_valid` outside LOAD is ignored and not accepted.
  - `mm_done` outside WAIT is ignored.
  - `mm_done` on the cycle the timeout is reached counts as done; no error.

## Timing
- Reset values (all outputs and all registers): 0. This covers `in_ready`, `mm_start`, `mm_a`, `mm_b`, `out_valid`, `out_data`, `out_last`, `err`, `busy`, the counters and the C register.
- Reset mid-operation clears everything; a partial load or partial drain is discarded.
- First `in_ready`=1 occurs 2 cycles after `rst_n` deasserts (IDLE, then LOAD).
- 8th input handshake at cycle t:
  - `mm_start`=1 at t+1.
  - If `mm_done` is first sampled high at t+1+k (k ≥ 1), then `out_valid`=1 with C00 at t+2+k.
- With `out_ready` held high, the four results occupy 4 consecutive cycles. `in_ready`=1 on the cycle after the C11 handshake.
- Timeout: `err` pulses at t+2+TIMEOUT; `in_ready`=1 at t+3+TIMEOUT.
- Minimum round trip is 8 + 1 + 1 + 4 cycles plus multiplier latency; there is no overlap between matrix pairs.

## Structure
- Package `matrix_pkg` holds:
  - default `DW`/`CW`;
  - the state enum;
  - element index constants (A00..B11);
  - pack/unpack functions for the flattened 2x2 buses.
- One natural sub-module: `matrix_out_ser`, a 4-entry C register plus the index counter and valid/ready/last logic, with `load`/`done` ports to the FSM.
- The top module contains the FSM, the input deserializer, A/B registers and the timeout counter.

## Test plan
- **Basic:** load A=[1 2;3 4], B=[5 6;7 8]; behavioral multiplier asserts done 2 cycles after start → outputs 19, 22, 43, 50, `out_last` only with 50, `mm_start` high exactly one cycle.
- **Signed:** A=[-1 2;3 -4], B=[5 -6;7 8] → `mm_a` packing checked per slot; outputs 9, 22, -13, -50.
- **Backpressure and input gaps:** random `in_valid` gaps, `out_ready` pattern 1,0,0,1,0,1,1 → no lost or duplicated element, `out_data` stable while stalled, `in_ready`=0 from START through last output.
- **Timeout:** TIMEOUT=8, multiplier never asserts done → `err` pulses at t+10, no `out_valid`. The next matrix pair then completes normally.
- **Done on boundary:** TIMEOUT=8, done asserted on the 8th WAIT cycle → no `err`, results delivered.
- **Reset mid-drain:** assert `rst_n`=0 after 2 outputs → all outputs 0 immediately. After release, a fresh pair yields correct C with no stale data.
